// File: rtl/m_ext_muldiv_unit.sv
// rtl/m_ext_muldiv_unit.sv - iterative RV32M multiply/divide execute unit
module m_ext_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mul_en,
  input  logic            mulh_en,
  input  logic            mulhsu_en,
  input  logic            mulhu_en,
  input  logic            div_en,
  input  logic            divu_en,
  input  logic            rem_en,
  input  logic            remu_en,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            rd_wr_en
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_t;

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  op_t             op_q, op_in;
  logic [7:0]      en_vec;
  logic            one_hot, accept, calc_last;
  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic            neg_q, special_q;
  logic [4:0]      rd_q;
  logic [CW-1:0]   cnt_q;

  logic            is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf, neg_in, is_div_q;
  logic [XLEN-1:0] a_mag, b_mag, spec_val;

  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  assign en_vec  = {remu_en, rem_en, divu_en, div_en, mulhu_en, mulhsu_en, mulh_en, mul_en};
  assign one_hot = (en_vec != 8'd0) && ((en_vec & (en_vec - 8'd1)) == 8'd0);
  assign accept  = (state_q == S_IDLE) && start && one_hot;
  // Special cases skip the iterations and finish after a single CALC cycle.
  assign calc_last = special_q || (cnt_q == CW'(XLEN));
  assign is_div_q  = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  // Decode the one-hot enables and prepare operand magnitudes and special results.
  always_comb begin
    op_in = OP_MUL;
    for (int i = 0; i < 8; i++) begin
      if (en_vec[i]) op_in = op_t'(3'(i));
    end
    is_div   = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    is_rem   = op_in inside {OP_REM, OP_REMU};
    a_signed = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    a_neg    = a_signed && rs1_data[XLEN-1];
    b_neg    = b_signed && rs2_data[XLEN-1];
    a_mag    = a_neg ? -rs1_data : rs1_data;
    b_mag    = b_neg ? -rs2_data : rs2_data;
    div_zero = is_div && (rs2_data == '0);
    div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (rs1_data == SMIN) && (rs2_data == '1);
    if (div_zero) spec_val = is_rem ? rs1_data : '1;
    else          spec_val = is_rem ? '0 : SMIN;
    // Remainder follows the dividend sign; quotient and product follow the sign xor.
    neg_in = is_rem ? a_neg : (a_neg ^ b_neg);
  end

  // One shift-add or restoring-subtract step, plus sign fix-up of the final value.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ok    = !div_diff[XLEN];
    prod      = {hi_q, lo_q};
    prod_fix  = neg_q ? -prod : prod;
    quo_fix   = neg_q ? -lo_q : lo_q;
    rem_fix   = neg_q ? -hi_q : hi_q;
    case (op_q)
      OP_MUL:                       final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = quo_fix;
      default:                      final_res = rem_fix;
    endcase
    if (special_q) final_res = lo_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and status outputs.
  always_comb begin
    state_d  = state_q;
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    rd_wr_en = (state_q == S_DONE) && (rd_out != 5'd0);
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CALC;
      S_CALC:  if (calc_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: load on accept, iterate in CALC, publish result on entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      op_q      <= OP_MUL;
      rd_q      <= 5'd0;
      cnt_q     <= '0;
      result    <= '0;
      rd_out    <= 5'd0;
    end else if (accept) begin
      op_q      <= op_in;
      rd_q      <= rd_in;
      neg_q     <= neg_in;
      special_q <= div_zero || div_ovf;
      cnt_q     <= '0;
      hi_q      <= '0;
      if (div_zero || div_ovf) begin
        lo_q <= spec_val;
        b_q  <= '0;
      end else if (is_div) begin
        lo_q <= a_mag;
        b_q  <= b_mag;
      end else begin
        lo_q <= b_mag;
        b_q  <= a_mag;
      end
    end else if (state_q == S_CALC) begin
      if (calc_last) begin
        result <= final_res;
        rd_out <= rd_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
        if (is_div_q) begin
          hi_q <= div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], div_ok};
        end else begin
          hi_q <= mul_sum[XLEN:1];
          lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_m_ext_muldiv_unit.sv
// tb/tb_m_ext_muldiv_unit.sv - self-checking bench for m_ext_muldiv_unit
module tb_m_ext_muldiv_unit;

  localparam int OP_MUL = 0, OP_MULH = 1, OP_MULHSU = 2, OP_MULHU = 3;
  localparam int OP_DIV = 4, OP_DIVU = 5, OP_REM = 6, OP_REMU = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  en = 8'd0;
  logic [31:0] rs1 = 32'd0, rs2 = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        busy, done, rd_wr_en;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  m_ext_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mul_en(en[0]), .mulh_en(en[1]), .mulhsu_en(en[2]), .mulhu_en(en[3]),
    .div_en(en[4]), .divu_en(en[5]), .rem_en(en[6]), .remu_en(en[7]),
    .rs1_data(rs1), .rs2_data(rs2), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .rd_wr_en(rd_wr_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result computed with plain wide arithmetic.
  function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] up;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'(b);
    ia = a;
    ib = b;
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin up = 64'(a) * 64'(b); return up[63:32]; end
      OP_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input int op, input logic [31:0] a, input logic [31:0] b);
    if (op >= OP_DIV && b == 0) return 1'b1;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int op_of(input logic [7:0] e);
    int r = 0;
    for (int i = 0; i < 8; i++) if (e[i]) r = i;
    return r;
  endfunction

  // Transaction-level model: one op in flight, known completion cycle.
  int          cyc = 0, acc = -100, lat = 0, k_issue = 0;
  bit          pend = 1'b0, chk_on = 1'b0;
  logic [31:0] pend_res = 32'd0, exp_res = 32'd0;
  logic [4:0]  pend_rd = 5'd0, exp_rd = 5'd0;

  // Advance the model on every rising edge from the same inputs the DUT samples.
  always @(posedge clk) begin
    int prev;
    bit was_busy;
    prev = cyc;
    cyc = cyc + 1;
    if (rst) begin
      pend = 1'b0;
      exp_res = 32'd0;
      exp_rd = 5'd0;
    end else begin
      was_busy = pend && prev >= acc && prev <= acc + lat;
      if (!was_busy && start && $countones(en) == 1) begin
        pend     = 1'b1;
        acc      = cyc;
        lat      = is_special(op_of(en), rs1, rs2) ? 1 : 33;
        pend_res = model(op_of(en), rs1, rs2);
        pend_rd  = rd_in;
      end
      if (pend && cyc == acc + lat) begin
        exp_res = pend_res;
        exp_rd  = pend_rd;
      end
    end
  end

  // Compare every DUT output against the model once per cycle.
  always @(negedge clk) begin
    bit eb, ed;
    if (chk_on) begin
      eb = pend && cyc >= acc && cyc <= acc + lat;
      ed = pend && cyc == acc + lat;
      chk("busy", {31'd0, busy}, {31'd0, eb});
      chk("done", {31'd0, done}, {31'd0, ed});
      chk("rd_wr_en", {31'd0, rd_wr_en}, {31'd0, ed && (exp_rd != 5'd0)});
      chk("result", result, exp_res);
      chk("rd_out", {27'd0, rd_out}, {27'd0, exp_rd});
    end
  end

  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(posedge clk);
    #2;
    en = 8'd0;
    en[op] = 1'b1;
    rs1 = a;
    rs2 = b;
    rd_in = rd;
    start = 1'b1;
    @(posedge clk);
    #1;
    k_issue = cyc;
    #1;
    start = 1'b0;
    en = 8'd0;
  endtask

  task automatic wait_done(input string name, input logic [31:0] lit, input int elat, input logic [4:0] rd);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no done expected done within 200 cycles", name);
    end else begin
      chk({name, " latency"}, 32'(cyc - k_issue), 32'(elat));
      chk(name, result, lit);
      chk({name, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
      chk({name, " rd_wr_en"}, {31'd0, rd_wr_en}, {31'd0, rd != 5'd0});
    end
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    int seen;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset rd_wr_en", {31'd0, rd_wr_en}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset rd_out", {27'd0, rd_out}, 32'd0);
    chk_on = 1'b1;

    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
    wait_done("mul", 32'hFFFF_FFEB, 33, 5'd5);
    issue(OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1);
    wait_done("mulh", 32'h4000_0000, 33, 5'd1);
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    wait_done("mulhsu", 32'hFFFF_FFFF, 33, 5'd2);
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    wait_done("mulhu", 32'hFFFF_FFFE, 33, 5'd3);
    issue(OP_DIV, 32'h0000_000A, 32'd0, 5'd4);
    wait_done("div by zero", 32'hFFFF_FFFF, 1, 5'd4);
    issue(OP_REMU, 32'h0000_000A, 32'd0, 5'd6);
    wait_done("remu by zero", 32'h0000_000A, 1, 5'd6);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
    wait_done("div overflow", 32'h8000_0000, 1, 5'd7);
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    wait_done("rem overflow", 32'd0, 1, 5'd8);
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd10);
    wait_done("rem neg", 32'hFFFF_FFFF, 33, 5'd10);
    issue(OP_REM, 32'd100, 32'hFFFF_FFF9, 5'd11);
    wait_done("rem pos neg", 32'd2, 33, 5'd11);
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 5'd13);
    wait_done("divu big", 32'h0FFF_FFFF, 33, 5'd13);

    // Start raised mid-operation must be ignored.
    issue(OP_DIVU, 32'd100, 32'd7, 5'd9);
    repeat (4) @(posedge clk);
    #2;
    start = 1'b1;
    en = 8'd0;
    en[OP_DIV] = 1'b1;
    rs1 = 32'd50;
    rs2 = 32'd3;
    repeat (3) @(posedge clk);
    #2;
    start = 1'b0;
    en = 8'd0;
    wait_done("divu busy ignore", 32'd14, 33, 5'd9);

    // Two enables at once: no accept.
    @(posedge clk);
    #2;
    start = 1'b1;
    en = 8'b0001_0001;
    rs1 = 32'd5;
    rs2 = 32'd6;
    @(posedge clk);
    #2;
    start = 1'b0;
    en = 8'd0;
    @(negedge clk);
    chk("multi enable busy", {31'd0, busy}, 32'd0);

    // rd = 0 completes without a write-back strobe.
    issue(OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd0);
    wait_done("div rd0", 32'hFFFF_FFF2, 33, 5'd0);

    // Reset in the middle of the iterations aborts the op.
    issue(OP_MUL, 32'h1234, 32'h5678, 5'd7);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort result", result, 32'd0);
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("no done after abort", 32'(seen), 32'd0);
    issue(OP_MUL, 32'd1000, 32'd1000, 5'd12);
    wait_done("mul after abort", 32'h000F_4240, 33, 5'd12);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
